// File: rtl/remote_comm_pkg.sv
// Shared types and constants for the quadcopter host link.
// Optional RX synchronizer selected by REMOTE_COMM_RX_SYNC_EN.
package remote_comm_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_HIGH,
      S_MID,
      S_LOW
   } send_state_t;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_t;

   localparam int         DEF_BAUD_DIV = 2604;
   localparam logic [7:0] ACK          = 8'hA5;
   localparam int         FRAME_BITS   = 10;

endpackage

// File: rtl/remote_comm_uart.sv
// 8N1 UART: back-to-back capable TX serializer and RX deserializer.
// Define REMOTE_COMM_RX_SYNC_EN to add a 2-flop RX synchronizer.
module remote_comm_uart
   import remote_comm_pkg::*;
#(
   parameter int BAUD_DIV = DEF_BAUD_DIV
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tx_start,
   input  logic [7:0] tx_data,
   output logic       tx,
   output logic       tx_done,
   input  logic       rx,
   input  logic       clr_rdy,
   output logic       rx_rdy,
   output logic [7:0] rx_data
);

   localparam logic [15:0] LAST     = 16'(BAUD_DIV - 1);
   localparam logic [15:0] HALF     = 16'(BAUD_DIV / 2 - 1);
   localparam logic [3:0]  STOP_BIT = 4'(FRAME_BITS - 1);

   logic [15:0] tx_cnt;
   logic [3:0]  tx_bit;
   logic [8:0]  tx_sh;
   logic        tx_busy;
   logic        tx_load;

   rx_state_t   rx_state;
   logic [15:0] rx_cnt;
   logic [2:0]  rx_bit;
   logic [7:0]  rx_sh;
   logic        rx_in;
   logic        rx_prev;
   logic        rx_fall;
   logic        rx_set;
   logic        rx_clr;

`ifdef REMOTE_COMM_RX_SYNC_EN
   logic [1:0] rx_sync;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) rx_sync <= 2'b11;
      else     rx_sync <= {rx_sync[0], rx};
   end

   assign rx_in = rx_sync[1];
`else
   assign rx_in = rx;
`endif

   // Done is combinational so the next frame can start with no idle gap
   assign tx_done = tx_busy && (tx_bit == STOP_BIT) && (tx_cnt == LAST);
   assign tx_load = tx_start && (!tx_busy || tx_done);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx      <= 1'b1;
         tx_busy <= 1'b0;
         tx_cnt  <= '0;
         tx_bit  <= '0;
         tx_sh   <= '1;
      end else if (tx_load) begin
         tx      <= 1'b0;
         tx_busy <= 1'b1;
         tx_cnt  <= '0;
         tx_bit  <= '0;
         tx_sh   <= {1'b1, tx_data};
      end else if (tx_busy) begin
         if (tx_cnt == LAST) begin
            tx_cnt <= '0;
            if (tx_done) begin
               tx_busy <= 1'b0;
               tx      <= 1'b1;
            end else begin
               tx_bit <= tx_bit + 4'd1;
               tx     <= tx_sh[0];
               tx_sh  <= {1'b1, tx_sh[8:1]};
            end
         end else begin
            tx_cnt <= tx_cnt + 16'd1;
         end
      end
   end

   assign rx_fall = (rx_state == RX_IDLE) && rx_prev && !rx_in;
   assign rx_set  = (rx_state == RX_STOP) && (rx_cnt == LAST);
   assign rx_clr  = clr_rdy || rx_fall;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_state <= RX_IDLE;
         rx_cnt   <= '0;
         rx_bit   <= '0;
         rx_sh    <= '0;
         rx_data  <= '0;
         rx_rdy   <= 1'b0;
         rx_prev  <= 1'b1;
      end else begin
         rx_prev <= rx_in;
         rx_rdy  <= rx_set || (rx_rdy && !rx_clr);
         unique case (rx_state)
            RX_IDLE: begin
               if (rx_fall) begin
                  rx_state <= RX_START;
                  rx_cnt   <= '0;
               end
            end
            RX_START: begin
               if (rx_cnt == HALF) begin
                  rx_cnt   <= '0;
                  rx_bit   <= '0;
                  rx_state <= rx_in ? RX_IDLE : RX_DATA;
               end else begin
                  rx_cnt <= rx_cnt + 16'd1;
               end
            end
            RX_DATA: begin
               if (rx_cnt == LAST) begin
                  rx_cnt <= '0;
                  rx_sh  <= {rx_in, rx_sh[7:1]};
                  rx_bit <= rx_bit + 3'd1;
                  if (rx_bit == 3'd7) rx_state <= RX_STOP;
               end else begin
                  rx_cnt <= rx_cnt + 16'd1;
               end
            end
            RX_STOP: begin
               if (rx_cnt == LAST) begin
                  rx_cnt   <= '0;
                  rx_data  <= rx_sh;
                  rx_state <= RX_IDLE;
               end else begin
                  rx_cnt <= rx_cnt + 16'd1;
               end
            end
            default: rx_state <= RX_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/remote_comm.sv
// Host command transmitter (cmd, data hi, data lo) and response receiver.
// RX synchronizer is enabled by defining REMOTE_COMM_RX_SYNC_EN.
module remote_comm
   import remote_comm_pkg::*;
#(
   parameter int BAUD_DIV = DEF_BAUD_DIV
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        RX,
   output logic        TX,
   input  logic [7:0]  cmd,
   input  logic [15:0] data,
   input  logic        send_cmd,
   output logic        cmd_sent,
   output logic [7:0]  resp,
   output logic        resp_rdy,
   input  logic        clr_resp_rdy
);

   send_state_t state;
   send_state_t state_nxt;
   logic [15:0] shadow;
   logic        accept;
   logic        tx_start;
   logic        tx_done;
   logic [7:0]  tx_data;

   assign accept = (state == S_IDLE) && send_cmd;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // The cmd byte goes straight to the serializer; only data needs holding
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow   <= '0;
         cmd_sent <= 1'b0;
      end else if (accept) begin
         shadow   <= data;
         cmd_sent <= 1'b0;
      end else if (state == S_LOW && tx_done) begin
         cmd_sent <= 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:  if (send_cmd) state_nxt = S_HIGH;
         S_HIGH:  if (tx_done)  state_nxt = S_MID;
         S_MID:   if (tx_done)  state_nxt = S_LOW;
         S_LOW:   if (tx_done)  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      tx_start = 1'b0;
      tx_data  = cmd;
      unique case (state)
         S_IDLE: begin
            tx_start = send_cmd;
            tx_data  = cmd;
         end
         S_HIGH: begin
            tx_start = tx_done;
            tx_data  = shadow[15:8];
         end
         S_MID: begin
            tx_start = tx_done;
            tx_data  = shadow[7:0];
         end
         default: begin
            tx_start = 1'b0;
            tx_data  = cmd;
         end
      endcase
   end

   remote_comm_uart #(
      .BAUD_DIV(BAUD_DIV)
   ) u_uart (
      .clk     (clk),
      .rst     (rst),
      .tx_start(tx_start),
      .tx_data (tx_data),
      .tx      (TX),
      .tx_done (tx_done),
      .rx      (RX),
      .clr_rdy (clr_resp_rdy),
      .rx_rdy  (resp_rdy),
      .rx_data (resp)
   );

endmodule

// File: tb/tb_remote_comm.sv
// Directed + randomized bench for remote_comm with a line-level UART model.
// Honours REMOTE_COMM_RX_SYNC_EN for the expected RX latency.
module tb_remote_comm;
   import remote_comm_pkg::*;

   localparam int B = 16;
`ifdef REMOTE_COMM_RX_SYNC_EN
   localparam int SYNC_LAT = 2;
`else
   localparam int SYNC_LAT = 0;
`endif
   localparam int TX_LAT = 30 * B + 1;
   localparam int RX_LAT = (19 * B) / 2 + 1 + SYNC_LAT;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rx_drv = 1'b1;
   logic        loop = 1'b0;
   logic        rx_line;
   logic        tx_line;
   logic [7:0]  cmd = '0;
   logic [15:0] data = '0;
   logic        send_cmd = 1'b0;
   logic        cmd_sent;
   logic [7:0]  resp;
   logic        resp_rdy;
   logic        clr_resp_rdy = 1'b0;

   int vectors = 0;
   int errs = 0;
   logic [7:0] tx_q[$];
   logic [7:0] rq[$];

   assign rx_line = loop ? tx_line : rx_drv;

   always #5 clk = ~clk;

   remote_comm #(.BAUD_DIV(B)) dut (
      .clk         (clk),
      .rst         (rst),
      .RX          (rx_line),
      .TX          (tx_line),
      .cmd         (cmd),
      .data        (data),
      .send_cmd    (send_cmd),
      .cmd_sent    (cmd_sent),
      .resp        (resp),
      .resp_rdy    (resp_rdy),
      .clr_resp_rdy(clr_resp_rdy)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Line monitor: decode every 8N1 frame seen on TX
   initial begin
      logic [7:0] b;
      logic st, sp, ab;
      forever begin
         @(negedge clk);
         if (!rst && tx_line === 1'b0) begin
            ab = 1'b0;
            b = '0;
            for (int c = 0; c < B / 2; c++) begin
               @(negedge clk);
               if (rst) ab = 1'b1;
            end
            st = tx_line;
            for (int i = 0; i < 8; i++) begin
               for (int c = 0; c < B; c++) begin
                  @(negedge clk);
                  if (rst) ab = 1'b1;
               end
               b[i] = tx_line;
            end
            for (int c = 0; c < B; c++) begin
               @(negedge clk);
               if (rst) ab = 1'b1;
            end
            sp = tx_line;
            if (!ab) begin
               chk("tx_start_bit", 32'(st), 32'h0);
               chk("tx_stop_bit", 32'(sp), 32'h1);
               tx_q.push_back(b);
            end
         end
      end
   end

   task automatic do_send(input logic [7:0] c, input logic [15:0] d,
                          input int inj, output int lat, output int rises);
      logic prev;
      @(negedge clk);
      cmd = c;
      data = d;
      send_cmd = 1'b1;
      lat = 0;
      rises = 0;
      prev = resp_rdy;
      for (int n = 1; n <= 700; n++) begin
         @(negedge clk);
         cmd = 8'($urandom);
         data = 16'($urandom);
         send_cmd = 1'b0;
         if (n == inj) begin
            send_cmd = 1'b1;
            cmd = 8'h03;
            data = 16'hFF80;
         end
         if (n == 1) chk("tx_start_lat", 32'(tx_line), 32'h0);
         if (resp_rdy && !prev) begin
            rises++;
            rq.push_back(resp);
         end
         prev = resp_rdy;
         if (cmd_sent) begin
            lat = n;
            break;
         end
      end
      send_cmd = 1'b0;
   endtask

   task automatic chk_frames(input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2);
      logic [7:0] exp[3];
      exp[0] = b0;
      exp[1] = b1;
      exp[2] = b2;
      repeat (4) @(negedge clk);
      chk("tx_nframes", 32'(tx_q.size()), 32'd3);
      if (tx_q.size() == 3) begin
         for (int i = 0; i < 3; i++) chk("tx_byte", 32'(tx_q[i]), 32'(exp[i]));
      end
      tx_q.delete();
   endtask

   task automatic drive_rx(input logic [7:0] b, input int clr_at,
                           output int rise);
      logic [9:0] bits;
      int n;
      bits = {1'b1, b, 1'b0};
      n = 0;
      rise = 0;
      @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         rx_drv = bits[i];
         for (int c = 0; c < B; c++) begin
            @(negedge clk);
            n++;
            clr_resp_rdy = (n == clr_at);
            if (resp_rdy && rise == 0 && n > 3) rise = n;
         end
      end
      clr_resp_rdy = 1'b0;
      rx_drv = 1'b1;
   endtask

   task automatic clear_rdy();
      @(negedge clk);
      clr_resp_rdy = 1'b1;
      @(negedge clk);
      clr_resp_rdy = 1'b0;
   endtask

   initial begin
      int lat, rises, rise;
      logic [7:0] rc, rb;
      logic [15:0] rd;

      repeat (3) @(negedge clk);
      chk("rst_tx", 32'(tx_line), 32'h1);
      chk("rst_cmd_sent", 32'(cmd_sent), 32'h0);
      chk("rst_resp", 32'(resp), 32'h0);
      chk("rst_resp_rdy", 32'(resp_rdy), 32'h0);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      do_send(8'h05, 16'h00FF, 0, lat, rises);
      chk("cmd_sent_lat", 32'(lat), 32'(TX_LAT));
      chk_frames(8'h05, 8'h00, 8'hFF);

      drive_rx(ACK, 0, rise);
      chk("rx_rise_lat", 32'(rise), 32'(RX_LAT));
      chk("rx_resp", 32'(resp), 32'(ACK));
      chk("rx_rdy", 32'(resp_rdy), 32'h1);
      clear_rdy();
      chk("clr_rdy", 32'(resp_rdy), 32'h0);
      chk("clr_resp_hold", 32'(resp), 32'(ACK));

      for (int k = 0; k < 4; k++) begin
         rb = 8'($urandom);
         drive_rx(rb, 0, rise);
         chk("rx_rand_resp", 32'(resp), 32'(rb));
         chk("rx_rand_rdy", 32'(resp_rdy), 32'h1);
         clear_rdy();
      end

      do_send(8'h02, 16'h0050, 5 * B, lat, rises);
      chk("ignore_lat", 32'(lat), 32'(TX_LAT));
      chk_frames(8'h02, 8'h00, 8'h50);
      repeat (12 * B) @(negedge clk);
      chk("ignore_no_more", 32'(tx_q.size()), 32'd0);
      chk("ignore_idle_tx", 32'(tx_line), 32'h1);

      loop = 1'b1;
      clear_rdy();
      rq.delete();
      do_send(8'h04, 16'h0080, 0, lat, rises);
      chk("loop_rises", 32'(rises), 32'd3);
      if (rq.size() == 3) begin
         chk("loop_r0", 32'(rq[0]), 32'h04);
         chk("loop_r1", 32'(rq[1]), 32'h00);
         chk("loop_r2", 32'(rq[2]), 32'h80);
      end
      chk("loop_resp", 32'(resp), 32'h80);
      chk_frames(8'h04, 8'h00, 8'h80);
      loop = 1'b0;
      repeat (4) @(negedge clk);

      clear_rdy();
      drive_rx(8'h3C, RX_LAT - 1, rise);
      chk("set_over_clr_rdy", 32'(resp_rdy), 32'h1);
      chk("set_over_clr_resp", 32'(resp), 32'h3C);

      @(negedge clk);
      cmd = 8'h77;
      data = 16'h1234;
      send_cmd = 1'b1;
      @(negedge clk);
      send_cmd = 1'b0;
      repeat (15 * B) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midrst_tx", 32'(tx_line), 32'h1);
      chk("midrst_cmd_sent", 32'(cmd_sent), 32'h0);
      chk("midrst_resp_rdy", 32'(resp_rdy), 32'h0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (12 * B) @(negedge clk);
      tx_q.delete();
      rc = 8'($urandom);
      rd = 16'($urandom);
      do_send(rc, rd, 0, lat, rises);
      chk("post_rst_lat", 32'(lat), 32'(TX_LAT));
      chk_frames(rc, rd[15:8], rd[7:0]);

      for (int k = 0; k < 3; k++) begin
         rc = 8'($urandom);
         rd = 16'($urandom);
         do_send(rc, rd, 0, lat, rises);
         chk("rand_lat", 32'(lat), 32'(TX_LAT));
         chk_frames(rc, rd[15:8], rd[7:0]);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
